// File: rtl/instr_fetch_unit.sv
// Instruction fetch responder: turns the pc's PCaddr into handshaked imem reads and returns instr/iready.
// Optional bus timeout fault is compiled in when IFETCH_TIMEOUT_EN is defined.
module instr_fetch_unit #(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] PCaddr,
  output logic [31:0] instr,
  output logic        iready,
  output logic        fetch_fault,
  output logic [31:0] mem_addr,
  output logic        mem_ren,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  o_dbg_state
);

  // Bus handshake: mem_ren is the request valid and stays high with a stable
  // mem_addr until the one-cycle mem_ack pulse; mem_ack is only honoured in REQ.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HIT   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_req_addr;
  logic [31:0] r_instr_q;
  logic [31:0] r_fault_addr;
  logic        w_misaligned;
  logic        w_addr_match;
  logic        w_timeout;
  logic        w_load_req;
  logic        w_enter_fault;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 31) begin : g_timeout_out_of_range
  end

  assign w_misaligned  = |PCaddr[1:0];
  assign w_addr_match  = (PCaddr == r_req_addr);
  assign w_load_req    = (w_next_state == S_REQ) && ((r_state != S_REQ) || mem_ack);
  assign w_enter_fault = (w_next_state == S_FAULT) && (r_state != S_FAULT);

`ifdef IFETCH_TIMEOUT_EN
  localparam logic [4:0] LP_CNT_LAST = 5'(TIMEOUT_CYCLES - 1);
  logic [4:0] r_cnt;

  // Counts REQ cycles without an ack; cleared whenever a new request starts.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= 5'd0;
    end else if (w_load_req) begin
      r_cnt <= 5'd0;
    end else if ((r_state == S_REQ) && !mem_ack) begin
      r_cnt <= r_cnt + 5'd1;
    end
  end

  assign w_timeout = (r_state == S_REQ) && !mem_ack && (r_cnt == LP_CNT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  w_next_state = w_misaligned ? S_FAULT : S_REQ;
      S_REQ: begin
        if (mem_ack) begin
          if (w_addr_match)      w_next_state = S_HIT;
          else if (w_misaligned) w_next_state = S_FAULT;
          else                   w_next_state = S_REQ;
        end else if (w_timeout) begin
          w_next_state = S_FAULT;
        end
      end
      S_HIT: begin
        if (!w_addr_match) w_next_state = w_misaligned ? S_FAULT : S_REQ;
      end
      S_FAULT: begin
        if (!w_misaligned && (PCaddr != r_fault_addr)) w_next_state = S_REQ;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // A timeout blames the stalled request address; otherwise the misaligned PCaddr.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_req_addr   <= 32'd0;
      r_instr_q    <= NOP_INSTR;
      r_fault_addr <= 32'd0;
    end else begin
      if (w_load_req) r_req_addr <= PCaddr;
      if ((r_state == S_REQ) && mem_ack) r_instr_q <= mem_rdata;
      if (w_enter_fault) r_fault_addr <= w_timeout ? r_req_addr : PCaddr;
    end
  end

  always_comb begin
    mem_ren     = (r_state == S_REQ);
    mem_addr    = r_req_addr;
    iready      = (r_state == S_HIT) && w_addr_match;
    fetch_fault = (r_state == S_FAULT);
    instr       = iready ? r_instr_q : NOP_INSTR;
    o_dbg_state = r_state;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: scripted scenarios plus randomized fetches checked
// against a latency/memory reference model; IFETCH_TIMEOUT_EN selects the timeout scenario.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        nRST;
  logic [31:0] PCaddr;
  logic [31:0] instr;
  logic        iready;
  logic        fetch_fault;
  logic [31:0] mem_addr;
  logic        mem_ren;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Bus responder controls and statistics
  bit resp_en      = 0;
  int wait_n       = 0;
  bit late_ack_req = 0;
  int ren_rises    = 0;
  int ack_count    = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .nRST        (nRST),
    .PCaddr      (PCaddr),
    .instr       (instr),
    .iready      (iready),
    .fetch_fault (fetch_fault),
    .mem_addr    (mem_addr),
    .mem_ren     (mem_ren),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference instruction memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return {a[15:0] ^ 16'hc3a5, a[31:16] ^ 16'h1234};
  endfunction

  // ---------------- bus responder ----------------
  initial begin
    int  wcnt;
    bit  prev_ren;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    wcnt      = 0;
    prev_ren  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ren && !prev_ren) ren_rises++;
      prev_ren = mem_ren;
      if (mem_ack) begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end else if (late_ack_req) begin
        mem_ack      = 1'b1;
        mem_rdata    = 32'hdeadbeef;
        late_ack_req = 1'b0;
      end else if (mem_ren && resp_en) begin
        if (wcnt >= wait_n) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          wcnt      = 0;
          ack_count++;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    nRST   = 1'b0;
    PCaddr = 32'h0;
    #3;
    n_checks++; if (iready !== 1'b0 || mem_ren !== 1'b0 || fetch_fault !== 1'b0)
      $display("FAIL reset_ctrl: got iready=%b mem_ren=%b fault=%b want 0/0/0", iready, mem_ren, fetch_fault);
    else n_pass++;
    n_checks++; if (instr !== NOP || mem_addr !== 32'h0)
      $display("FAIL reset_data: got instr=%h mem_addr=%h want %h/0", instr, mem_addr, NOP);
    else n_pass++;
    @(negedge clk);
    nRST    = 1'b1;
    resp_en = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (mem_ren !== 1'b1)
      $display("FAIL reset_pre_req: got mem_ren=%b want 1", mem_ren);
    else n_pass++;
    nRST = 1'b0;
    #1;
    n_checks++; if (iready !== 1'b0 || mem_ren !== 1'b0 || instr !== NOP || mem_addr !== 32'h0 || fetch_fault !== 1'b0)
      $display("FAIL reset_mid_req: got iready=%b mem_ren=%b instr=%h addr=%h fault=%b want 0/0/%h/0/0",
               iready, mem_ren, instr, mem_addr, fetch_fault, NOP);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_wait();
    resp_en = 1'b1;
    wait_n  = 0;
    nRST    = 1'b1;
    PCaddr  = 32'h100;
    @(negedge clk);
    n_checks++; if (mem_ren !== 1'b1 || mem_addr !== 32'h100 || iready !== 1'b0)
      $display("FAIL zw_req: got ren=%b addr=%h iready=%b want 1/100/0", mem_ren, mem_addr, iready);
    else n_pass++;
    @(negedge clk);
    n_checks++; if (iready !== 1'b1 || instr !== 32'h00500093)
      $display("FAIL zw_hit: got iready=%b instr=%h want 1/00500093", iready, instr);
    else n_pass++;
  endtask

  task automatic test_redirect();
    int  acks0;
    bit  ren_dropped;
    bit  early;
    bit  saw_104;
    bit  hit;
    acks0       = ack_count;
    ren_dropped = 1'b0;
    early       = 1'b0;
    saw_104     = 1'b0;
    hit         = 1'b0;
    wait_n      = 3;
    PCaddr      = 32'h104;
    for (int k = 1; k <= 40 && !hit; k++) begin
      @(negedge clk);
      if (iready) begin
        hit = 1'b1;
      end else begin
        if (mem_ren !== 1'b1) ren_dropped = 1'b1;
        if (mem_addr == 32'h104) saw_104 = 1'b1;
      end
      if (k == 2) PCaddr = 32'h200;
      if (k == 2 && mem_addr !== 32'h104) early = 1'b1;
    end
    n_checks++; if (!hit)
      $display("FAIL redir_timeout: got no iready within 40 cycles want iready=1");
    else n_pass++;
    n_checks++; if (ren_dropped || !saw_104 || early)
      $display("FAIL redir_ren_held: got dropped=%b saw_104=%b early_switch=%b want 0/1/0", ren_dropped, saw_104, early);
    else n_pass++;
    n_checks++; if (instr !== mem_word(32'h200) || mem_addr !== 32'h200)
      $display("FAIL redir_data: got instr=%h addr=%h want %h/200", instr, mem_addr, mem_word(32'h200));
    else n_pass++;
    n_checks++; if (ack_count - acks0 != 2)
      $display("FAIL redir_acks: got %0d bus reads want 2", ack_count - acks0);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    wait_n = 0;
    PCaddr = 32'h102;
    @(negedge clk);
    n_checks++; if (fetch_fault !== 1'b1 || mem_ren !== 1'b0 || iready !== 1'b0 || instr !== NOP)
      $display("FAIL mis_fault: got fault=%b ren=%b iready=%b instr=%h want 1/0/0/%h", fetch_fault, mem_ren, iready, instr, NOP);
    else n_pass++;
    late_ack_req = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (fetch_fault !== 1'b1 || iready !== 1'b0 || mem_ren !== 1'b0)
      $display("FAIL mis_hold: got fault=%b iready=%b ren=%b want 1/0/0", fetch_fault, iready, mem_ren);
    else n_pass++;
    PCaddr = 32'h108;
    @(negedge clk);
    n_checks++; if (fetch_fault !== 1'b0 || mem_ren !== 1'b1 || mem_addr !== 32'h108)
      $display("FAIL mis_exit: got fault=%b ren=%b addr=%h want 0/1/108", fetch_fault, mem_ren, mem_addr);
    else n_pass++;
    @(negedge clk);
    n_checks++; if (iready !== 1'b1 || instr !== mem_word(32'h108))
      $display("FAIL mis_refetch: got iready=%b instr=%h want 1/%h", iready, instr, mem_word(32'h108));
    else n_pass++;
  endtask

`ifdef IFETCH_TIMEOUT_EN
  task automatic test_timeout();
    bit bad;
    bad     = 1'b0;
    resp_en = 1'b0;
    PCaddr  = 32'h300;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (mem_ren !== 1'b1 || fetch_fault !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad)
      $display("FAIL to_req_phase: got ren/fault deviation in first 16 REQ cycles want ren=1 fault=0");
    else n_pass++;
    @(negedge clk);
    n_checks++; if (fetch_fault !== 1'b1 || mem_ren !== 1'b0)
      $display("FAIL to_fault: got fault=%b ren=%b want 1/0", fetch_fault, mem_ren);
    else n_pass++;
    late_ack_req = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (iready !== 1'b0 || fetch_fault !== 1'b1 || instr !== NOP)
      $display("FAIL to_late_ack: got iready=%b fault=%b instr=%h want 0/1/%h", iready, fetch_fault, instr, NOP);
    else n_pass++;
    resp_en = 1'b1;
    PCaddr  = 32'h304;
    repeat (2) @(negedge clk);
    n_checks++; if (iready !== 1'b1 || fetch_fault !== 1'b0 || instr !== mem_word(32'h304))
      $display("FAIL to_recover: got iready=%b fault=%b instr=%h want 1/0/%h", iready, fetch_fault, instr, mem_word(32'h304));
    else n_pass++;
  endtask
`else
  task automatic test_no_timeout();
    bit bad;
    bit hit;
    bad     = 1'b0;
    hit     = 1'b0;
    resp_en = 1'b0;
    PCaddr  = 32'h300;
    repeat (40) begin
      @(negedge clk);
      if (mem_ren !== 1'b1 || fetch_fault !== 1'b0 || iready !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad)
      $display("FAIL nt_wait: got ren/fault/iready deviation over 40 cycles want 1/0/0");
    else n_pass++;
    resp_en = 1'b1;
    for (int k = 0; k < 6 && !hit; k++) begin
      @(negedge clk);
      hit = iready;
    end
    n_checks++; if (!hit || instr !== mem_word(32'h300))
      $display("FAIL nt_complete: got iready=%b instr=%h want 1/%h", iready, instr, mem_word(32'h300));
    else n_pass++;
  endtask
`endif

  task automatic test_stable_hit();
    int  rises0;
    bit  bad;
    rises0 = ren_rises;
    bad    = 1'b0;
    wait_n = 1;
    PCaddr = 32'h400;
    repeat (3) @(negedge clk);
    n_checks++; if (iready !== 1'b1 || instr !== mem_word(32'h400))
      $display("FAIL st_fetch: got iready=%b instr=%h want 1/%h", iready, instr, mem_word(32'h400));
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) late_ack_req = 1'b1;
      @(negedge clk);
      if (iready !== 1'b1 || mem_ren !== 1'b0 || instr !== mem_word(32'h400)) bad = 1'b1;
    end
    n_checks++; if (bad)
      $display("FAIL st_hold: got iready/ren/instr change while PCaddr stable want 1/0/%h", mem_word(32'h400));
    else n_pass++;
    n_checks++; if (ren_rises - rises0 != 1)
      $display("FAIL st_one_txn: got %0d mem_ren transactions want 1", ren_rises - rises0);
    else n_pass++;
  endtask

  // Model: from HIT, a new aligned PCaddr with w wait states gives iready
  // exactly 2+w cycles later, carrying the memory word at PCaddr.
  task automatic test_random();
    logic [31:0] a;
    int          w;
    logic        exp_rdy;
    for (int it = 0; it < 24; it++) begin
      do a = $urandom() & 32'hffff_fffc; while (a == PCaddr);
      w = $urandom_range(0, 3);
      @(negedge clk);
      wait_n = w;
      PCaddr = a;
      for (int k = 1; k <= 2 + w; k++) begin
        @(negedge clk);
        exp_rdy = (k == 2 + w);
        n_checks++; if (iready !== exp_rdy)
          $display("FAIL rnd_latency: it=%0d addr=%h k=%0d got iready=%b want %b", it, a, k, iready, exp_rdy);
        else n_pass++;
      end
      n_checks++; if (instr !== mem_word(a) || mem_addr !== a)
        $display("FAIL rnd_data: addr=%h got instr=%h mem_addr=%h want %h/%h", a, instr, mem_addr, mem_word(a), a);
      else n_pass++;
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_zero_wait();
    test_redirect();
    test_misaligned();
`ifdef IFETCH_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_stable_hit();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
